// File: rtl/irq_ctrl.sv
// Interrupt controller: latches, masks and prioritises NSRC sources and tracks one in-service id.
// Latency: a source change reaches HWInt/IRQ after two clock edges; Dout is combinational from Addr.
// Backpressure: none; every register access completes in its cycle and reads have no side effects.
module irq_ctrl #(
  parameter logic [31:0]     BASE     = 32'h0000_7F30,
  parameter int              NSRC     = 6,
  parameter logic [NSRC-1:0] MODE_RST = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [29:0]     Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  input  logic [NSRC-1:0] irq_src,
  output logic [NSRC-1:0] HWInt,
  output logic            IRQ
);

  // Register window expressed as a word address, so Addr compares directly.
  localparam logic [29:0] BASE_W = BASE[31:2];
  localparam int          IDW    = 3;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] SERVICE = 1'b1;

  logic [NSRC-1:0] en;
  logic [NSRC-1:0] mode;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] edge_pend;
  logic [0:0]      state;
  logic [IDW-1:0]  srv_id;

  logic [29:0]     off;
  logic            in_win;
  logic            wr_en;
  logic            wr_mode;
  logic            wr_pend;
  logic            wr_claim;
  logic            wr_complete;

  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] allow;
  logic [NSRC-1:0] elig;
  logic            valid;
  logic [IDW-1:0]  winner_id;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pend_w1c;
  logic [NSRC-1:0] claim_clr;
  logic [NSRC-1:0] mode_nxt;
  logic [NSRC-1:0] edge_pend_nxt;
  logic            unused_din;

  // Addresses below BASE wrap to a large offset, so one compare bounds the window.
  assign off    = Addr - BASE_W;
  assign in_win = (off < 30'd5);

  assign wr_en       = WE && in_win && (off == 30'd0);
  assign wr_mode     = WE && in_win && (off == 30'd1);
  assign wr_pend     = WE && in_win && (off == 30'd2);
  assign wr_claim    = WE && in_win && (off == 30'd3);
  assign wr_complete = WE && in_win && (off == 30'd4);

  // Only the low NSRC data bits carry register content.
  assign unused_din = ^Din[31:NSRC];

  // Edge-mode sources present their latched bit, level sources the sampled line.
  assign pend  = (mode & edge_pend) | (~mode & src_q);
  assign elig  = pend & en & allow;
  assign valid = |elig;

  // While servicing, only strictly higher-priority (lower index) sources may preempt.
  always_comb begin
    allow = '0;
    for (int i = 0; i < NSRC; i++) begin
      allow[i] = (state == IDLE) || (i < int'(srv_id));
    end
  end

  // Lowest eligible index wins.
  always_comb begin
    winner_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) winner_id = IDW'(i);
    end
  end

  // Next edge-latch value: a fresh rising edge beats any clear in the same cycle, and a
  // source leaving edge mode drops its latched bit.
  always_comb begin
    rise      = irq_src & ~src_q;
    mode_nxt  = wr_mode ? Din[NSRC-1:0] : mode;
    pend_w1c  = wr_pend ? Din[NSRC-1:0] : '0;
    claim_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      claim_clr[i] = wr_claim && valid && (winner_id == IDW'(i));
    end
    edge_pend_nxt = ((edge_pend & ~(pend_w1c | claim_clr)) | (rise & mode)) & mode_nxt;
  end

  // Configuration registers, source sampling and edge latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en        <= '0;
      mode      <= MODE_RST;
      src_q     <= '0;
      edge_pend <= '0;
    end else begin
      if (wr_en) en <= Din[NSRC-1:0];
      mode      <= mode_nxt;
      src_q     <= irq_src;
      edge_pend <= edge_pend_nxt;
    end
  end

  // Service tracking: claim enters or preempts (single level, no stack), complete returns to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      srv_id <= '0;
    end else if (wr_claim && valid) begin
      state  <= SERVICE;
      srv_id <= winner_id;
    end else if (wr_complete && (state == SERVICE)) begin
      state  <= IDLE;
    end
  end

  // Registered request lines toward the CPU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HWInt <= '0;
      IRQ   <= 1'b0;
    end else begin
      HWInt <= elig;
      IRQ   <= valid;
    end
  end

  // Read mux; unmapped offsets and unused high bits read zero.
  always_comb begin
    Dout = '0;
    if (in_win) begin
      case (off[2:0])
        3'd0: Dout[NSRC-1:0] = en;
        3'd1: Dout[NSRC-1:0] = mode;
        3'd2: Dout[NSRC-1:0] = pend;
        3'd3: begin
          Dout[31]      = valid;
          Dout[IDW-1:0] = winner_id;
        end
        3'd4: begin
          Dout[31]      = (state == SERVICE);
          Dout[IDW-1:0] = srv_id;
        end
        default: Dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed vectors with literal expectations plus a per-cycle reference model.
// Latency: model is updated on each rising edge and compared on the falling edge.
// Backpressure: not applicable; stimulus is driven one register access per cycle.
module tb_irq_ctrl;

  localparam logic [29:0] BW = 30'h1FCC;  // 0x7F30 >> 2

  logic        clk;
  logic        rst;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic [5:0]  irq_src;
  logic [5:0]  HWInt;
  logic        IRQ;

  int n_chk  = 0;
  int n_pass = 0;

  irq_ctrl dut (
    .clk     (clk),
    .reset   (rst),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .irq_src (irq_src),
    .HWInt   (HWInt),
    .IRQ     (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (per-source booleans) ----------------
  bit          m_en   [6];
  bit          m_mode [6];
  bit          m_lvl  [6];
  bit          m_lat  [6];
  bit          m_busy;
  int          m_srv;
  logic [5:0]  m_hw;
  bit          m_irq;

  int          mw;
  int          moff;
  bit          mclr   [6];
  bit          mnmode [6];
  logic [5:0]  mhw;

  function automatic bit m_pending(input int i);
    return m_mode[i] ? m_lat[i] : m_lvl[i];
  endfunction

  function automatic bit m_eligible(input int i);
    return m_pending(i) && m_en[i] && (!m_busy || i < m_srv);
  endfunction

  function automatic int m_winner();
    for (int i = 0; i < 6; i++) if (m_eligible(i)) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input logic [29:0] a);
    logic [31:0] r;
    int          w;
    r = '0;
    if (a >= BW && a <= BW + 30'd4) begin
      case (int'(a - BW))
        0: for (int i = 0; i < 6; i++) r[i] = m_en[i];
        1: for (int i = 0; i < 6; i++) r[i] = m_mode[i];
        2: for (int i = 0; i < 6; i++) r[i] = m_pending(i);
        3: begin
          w = m_winner();
          if (w >= 0) r = {1'b1, 28'b0, 3'(w)};
        end
        4: r = {m_busy, 28'b0, 3'(m_srv)};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        m_en[i] = 0; m_mode[i] = 0; m_lvl[i] = 0; m_lat[i] = 0;
      end
      m_busy = 0; m_srv = 0; m_hw = '0; m_irq = 0;
    end else begin
      mw = m_winner();
      for (int i = 0; i < 6; i++) begin
        mhw[i]    = m_eligible(i);
        mclr[i]   = 0;
        mnmode[i] = m_mode[i];
      end
      if (WE && Addr >= BW && Addr <= BW + 30'd4) begin
        moff = int'(Addr - BW);
        case (moff)
          0: for (int i = 0; i < 6; i++) m_en[i] = Din[i];
          1: for (int i = 0; i < 6; i++) mnmode[i] = Din[i];
          2: for (int i = 0; i < 6; i++) mclr[i] = Din[i];
          3: if (mw >= 0) begin m_busy = 1; m_srv = mw; mclr[mw] = 1; end
          4: m_busy = 0;
          default: ;
        endcase
      end
      for (int i = 0; i < 6; i++) begin
        if (m_mode[i] && irq_src[i] && !m_lvl[i]) m_lat[i] = 1;
        else if (mclr[i]) m_lat[i] = 0;
        if (!mnmode[i]) m_lat[i] = 0;
        m_mode[i] = mnmode[i];
        m_lvl[i]  = irq_src[i];
      end
      m_hw  = mhw;
      m_irq = |mhw;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, want, $time);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_hwint", {26'b0, HWInt}, {26'b0, m_hw});
      chk("model_irq",   {31'b0, IRQ},   {31'b0, m_irq});
      chk("model_dout",  Dout,           m_read(Addr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    Addr = BW + 30'(off);
    Din  = d;
    WE   = 1'b1;
    step();
    WE   = 1'b0;
    Din  = '0;
    Addr = '0;
  endtask

  task automatic rd(input string nm, input logic [29:0] a, input logic [31:0] want);
    Addr = a;
    #1;
    chk(nm, Dout, want);
    Addr = '0;
  endtask

  task automatic hw(input string nm, input logic [5:0] want);
    chk(nm, {26'b0, HWInt}, {26'b0, want});
  endtask

  initial begin
    rst = 1'b1; Addr = '0; WE = 1'b0; Din = '0; irq_src = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    hw("rst_hwint", 6'h00);
    chk("rst_irq", {31'b0, IRQ}, 32'h0);
    rd("rst_en",       BW + 30'd0, 32'h0);
    rd("rst_mode",     BW + 30'd1, 32'h0);
    rd("rst_complete", BW + 30'd4, 32'h0);

    // Level source 1
    wr(0, 32'h3F);
    wr(1, 32'h0);
    repeat (4) step();
    irq_src[1] = 1'b1;
    step();
    hw("lvl_one_edge", 6'h00);
    step();
    hw("lvl_two_edges", 6'b000010);
    chk("lvl_irq", {31'b0, IRQ}, 32'h1);
    rd("lvl_claim", BW + 30'd3, 32'h8000_0001);
    rd("lvl_pend",  BW + 30'd2, 32'h0000_0002);
    irq_src[1] = 1'b0;
    step();
    hw("lvl_fall_one", 6'b000010);
    step();
    hw("lvl_fall_two", 6'h00);

    // Edge source 2
    wr(1, 32'h04);
    irq_src[2] = 1'b1;
    step();
    irq_src[2] = 1'b0;
    rd("edge_pend_set", BW + 30'd2, 32'h4);
    step();
    rd("edge_pend_held", BW + 30'd2, 32'h4);
    hw("edge_hwint", 6'b000100);
    wr(3, 32'h0);
    rd("edge_complete", BW + 30'd4, 32'h8000_0002);
    rd("edge_pend_clr", BW + 30'd2, 32'h0);
    step();
    hw("edge_hwint_clr", 6'h00);

    // Preemption while serving id 2
    irq_src[4] = 1'b1;
    step(); step();
    hw("pre_low_masked", 6'h00);
    irq_src[0] = 1'b1;
    step(); step();
    hw("pre_high_shown", 6'b000001);
    rd("pre_claim_rd", BW + 30'd3, 32'h8000_0000);
    wr(3, 32'h0);
    rd("pre_srv0", BW + 30'd4, 32'h8000_0000);
    irq_src[0] = 1'b0;
    step(); step();
    hw("pre_none_allowed", 6'h00);
    wr(4, 32'h0);
    rd("pre_idle", BW + 30'd4, 32'h0);
    step();
    hw("pre_after_complete", 6'b010000);
    irq_src[4] = 1'b0;
    step(); step();

    // Set beats W1C; set beats claim clear
    wr(1, 32'h0C);
    irq_src[3] = 1'b1;
    wr(2, 32'h8);
    rd("race_w1c", BW + 30'd2, 32'h8);
    wr(2, 32'h8);
    rd("w1c_clears", BW + 30'd2, 32'h0);
    irq_src[3] = 1'b0;
    step();
    irq_src[3] = 1'b1;
    step();
    irq_src[3] = 1'b0;
    step();
    irq_src[3] = 1'b1;
    wr(3, 32'h0);
    rd("race_claim_pend", BW + 30'd2, 32'h8);
    rd("race_claim_srv",  BW + 30'd4, 32'h8000_0003);
    irq_src[3] = 1'b0;
    wr(4, 32'h0);
    wr(2, 32'h8);
    rd("race_cleanup", BW + 30'd2, 32'h0);
    step();

    // Boundaries
    wr(3, 32'h0);
    rd("claim_empty", BW + 30'd4, 32'h0000_0003);
    wr(4, 32'h0);
    rd("complete_idle", BW + 30'd4, 32'h0000_0003);
    wr(5, 32'hFFFF_FFFF);
    rd("off5_read",  BW + 30'd5, 32'h0);
    rd("off7_read",  BW + 30'd7, 32'h0);
    rd("below_base", BW - 30'd1, 32'h0);
    rd("off5_en",    BW + 30'd0, 32'h3F);
    rd("off5_mode",  BW + 30'd1, 32'h0C);

    // EN masks without clearing the latch
    wr(0, 32'h0);
    irq_src[2] = 1'b1;
    step();
    irq_src[2] = 1'b0;
    step(); step();
    hw("en0_masked", 6'h00);
    rd("en0_pend", BW + 30'd2, 32'h4);
    wr(0, 32'h3F);
    hw("en1_same_edge", 6'h00);
    step();
    hw("en1_next_edge", 6'b000100);

    // MODE 1->0 drops the latch; 0->1 does not restore it
    wr(1, 32'h08);
    rd("mode_fall_pend", BW + 30'd2, 32'h0);
    wr(1, 32'h0C);
    rd("mode_rise_pend", BW + 30'd2, 32'h0);
    step();

    // Asynchronous reset in the middle of service
    irq_src[2] = 1'b1;
    step();
    irq_src[2] = 1'b0;
    step();
    wr(3, 32'h0);
    rd("svc_srv2", BW + 30'd4, 32'h8000_0002);
    irq_src[0] = 1'b1;
    step(); step();
    hw("svc_hwint", 6'b000001);
    #2;
    rst = 1'b1;
    #1;
    hw("arst_hwint", 6'h00);
    chk("arst_irq", {31'b0, IRQ}, 32'h0);
    rd("arst_complete", BW + 30'd4, 32'h0);
    rd("arst_en",       BW + 30'd0, 32'h0);
    rd("arst_mode",     BW + 30'd1, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    irq_src = '0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller between the interrupt sources (Timer0_IRQ, Timer1_IRQ, external interrupt, spares) and the CPU HWInt input.
- Latches, masks and prioritises requests, and tracks one in-service interrupt with higher-priority preemption.
- Configured and acknowledged by the CPU through word-register accesses at 0x7F30–0x7F43, decoded by the system bridge in the same way as the timers.

Parameters:
BASE, 32'h0000_7F30, word-aligned base address of the register window
NSRC, 6, number of sources; index 0 = highest priority
MODE_RST, 6'b000000, MODE reset value; bit=1 edge-triggered, bit=0 level

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
Addr  in  30  word address [31:2] from bridge
WE  in  1  write enable, a full-word write already qualified by the bridge
Din  in  32  write data
Dout  out  32  read data, combinational from Addr
irq_src  in  NSRC  raw source requests
HWInt  out  NSRC  registered, masked requests to CPU
IRQ  out  1  registered OR of HWInt

Behaviour:
- Registers, by word offset from BASE:
  - 0 EN: RW, bits[NSRC-1:0].
  - 1 MODE: RW.
  - 2 PEND: reads pending; a write-1 clears edge-mode bits.
  - 3 CLAIM: read returns {valid[31], 28'b0, winner_id[2:0]}; any write claims the winner.
  - 4 COMPLETE: read returns {busy[31], 28'b0, srv_id[2:0]}; any write ends service.
- Offsets 5–7 and addresses outside the window: read 0, writes ignored. Unused high bits read 0.
- Reset (async, any time, including mid-service):
  - EN=0, MODE=MODE_RST, src_q=0, edge_pend=0, state=IDLE, srv_id=0, HWInt=0, IRQ=0.
- Sampling:
  - src_q <= irq_src every edge.
  - Edge bit: edge_pend[i] set when irq_src[i]&~src_q[i] at an edge.
  - pend[i] = MODE[i] ? edge_pend[i] : src_q[i].
- Qualification and winner:
  - elig = pend & EN & allow.
  - allow = all ones in IDLE; in SERVICE, only bits with index < srv_id.
  - winner_id = lowest set index of elig; valid = |elig.
- Output latency:
  - HWInt <= elig, IRQ <= |elig, both registered.
  - Example: irq_src rises before edge k → pend after edge k → HWInt after edge k+1.
- FSM, two states:
  - IDLE → SERVICE: CLAIM write with valid=1. Latches srv_id=winner_id; clears edge_pend[winner_id] if edge mode. Level sources are not cleared; the device deasserts.
  - SERVICE: a CLAIM write with valid=1 (higher-priority source) performs a single-level preemption: srv_id is overwritten, the previous id is not stacked, and software saves it.
  - SERVICE → IDLE: COMPLETE write; srv_id unchanged until the next claim.
  - CLAIM write with valid=0: ignored, no state change.
  - COMPLETE write in IDLE: ignored.
- Simultaneous events:
  - A new edge and a PEND W1C on the same bit in the same cycle: set wins.
  - A new edge on winner_id and a CLAIM on the same cycle: bit stays set.
- MODE write changing bit i 1→0 clears edge_pend[i]. A 0→1 change does not set it; it waits for the next rising edge.
- EN=0 masks without clearing edge_pend; re-enabling exposes the still-latched request.
- Dout is purely combinational; reads have no side effects, so pipeline stalls and replays are safe.

Test Plan:
- Reset mid-service: state=SERVICE, srv_id=2, assert reset asynchronously → HWInt=0, IRQ=0 immediately; COMPLETE read = 0; EN read = 0.
- Level, EN=6'h3F, MODE=0, irq_src[1] high from cycle 10:
  - HWInt=6'b000010 two edges later.
  - CLAIM read = 32'h8000_0001.
  - Deassert irq_src[1] → HWInt=0 two edges later.
- Edge, MODE=6'b000100:
  - 1-cycle pulse on irq_src[2] → PEND=6'b000100, held after the pulse ends.
  - CLAIM write → COMPLETE read 32'h8000_0002, PEND=0, HWInt=0 next edge.
- Preemption: in SERVICE srv_id=2:
  - Level src 4 pending → HWInt=0.
  - Src 0 asserts → HWInt=6'b000001.
  - CLAIM write → srv_id=0.
  - COMPLETE write → IDLE, HWInt=6'b010000.
- Race: edge on src 3 in the same cycle as a PEND write of 6'b001000 → PEND reads 6'b001000 afterward.
- Boundaries:
  - CLAIM write with nothing pending → state stays IDLE.
  - Write to BASE+0x14 → no register change, reads 0.
  - EN=0 with pending edge → HWInt=0; EN back to 1 → HWInt set next edge.
